// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard controller.
// The datapath side is the master and drives the stage info; the controller side is the slave and drives the controls.
interface pipeline_hazard_ctrl_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_usesRs;
    logic        id_usesRt;
    logic [4:0]  ex_rd;
    logic        ex_ifWriteRegsFile;
    logic [4:0]  mem_rd;
    logic        mem_ifWriteRegsFile;
    logic        id_branchTaken;
    logic        mem_busy;
    logic        pc_write;
    logic        ifid_write;
    logic        ifid_flush;
    logic        idex_bubble;
    logic        pipe_freeze;
    logic [1:0]  state;
    logic [15:0] stall_cycles;
    logic [15:0] freeze_cycles;
    logic        mem_timeout;

    modport master (
        output id_rs, id_rt, id_usesRs, id_usesRt,
        output ex_rd, ex_ifWriteRegsFile, mem_rd, mem_ifWriteRegsFile,
        output id_branchTaken, mem_busy,
        input  pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
        input  state, stall_cycles, freeze_cycles, mem_timeout
    );

    modport slave (
        input  id_rs, id_rt, id_usesRs, id_usesRt,
        input  ex_rd, ex_ifWriteRegsFile, mem_rd, mem_ifWriteRegsFile,
        input  id_branchTaken, mem_busy,
        output pc_write, ifid_write, ifid_flush, idex_bubble, pipe_freeze,
        output state, stall_cycles, freeze_cycles, mem_timeout
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/freeze controller for a 5-stage pipeline: load-use style RAW hazards against EX/MEM,
// taken-branch flushes and data-memory wait freezes, with saturating event counters and a wait watchdog.
module pipeline_hazard_ctrl (
    input  logic                    clk,
    input  logic                    rst,
    pipeline_hazard_ctrl_if.slave   hz_if
);
    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HAZ  = 2'd1,
        MEMW = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic [15:0] freeze_cycles_q, freeze_cycles_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        mem_timeout_q, mem_timeout_d;

    logic        pc_write_d;
    logic        ifid_write_d;
    logic        ifid_flush_d;
    logic        idex_bubble_d;
    logic        pipe_freeze_d;

    logic [1:0][4:0] src_reg;
    logic [1:0]      src_used;
    logic [1:0]      src_hit;
    logic            hz;

    assign src_reg[0]  = hz_if.id_rs;
    assign src_reg[1]  = hz_if.id_rt;
    assign src_used[0] = hz_if.id_usesRs;
    assign src_used[1] = hz_if.id_usesRt;

    // Only EX and MEM writers matter: WB writes the register file before ID reads it.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_reg[gi] != 5'd0) &&
                ((hz_if.ex_ifWriteRegsFile  && (hz_if.ex_rd  == src_reg[gi])) ||
                 (hz_if.mem_ifWriteRegsFile && (hz_if.mem_rd == src_reg[gi])));
        end
    endgenerate

    assign hz = |src_hit;

    always_comb begin
        pc_write_d    = 1'b1;
        ifid_write_d  = 1'b1;
        ifid_flush_d  = 1'b0;
        idex_bubble_d = 1'b0;
        pipe_freeze_d = 1'b0;
        state_d       = RUN;
        if (rst) begin
            pc_write_d    = 1'b0;
            ifid_write_d  = 1'b0;
            ifid_flush_d  = 1'b1;
            idex_bubble_d = 1'b1;
        end else if (hz_if.mem_busy) begin
            pc_write_d    = 1'b0;
            ifid_write_d  = 1'b0;
            pipe_freeze_d = 1'b1;
            state_d       = MEMW;
        end else if (hz) begin
            // A branch decided on stale operands is ignored until the hazard clears.
            pc_write_d    = 1'b0;
            ifid_write_d  = 1'b0;
            idex_bubble_d = 1'b1;
            state_d       = HAZ;
        end else if (hz_if.id_branchTaken) begin
            ifid_flush_d  = 1'b1;
        end
    end

    always_comb begin
        stall_cycles_d  = stall_cycles_q;
        freeze_cycles_d = freeze_cycles_q;
        wait_cnt_d      = wait_cnt_q;
        mem_timeout_d   = mem_timeout_q;
        if (idex_bubble_d && (stall_cycles_q != 16'hFFFF)) begin
            stall_cycles_d = stall_cycles_q + 16'd1;
        end
        if (pipe_freeze_d && (freeze_cycles_q != 16'hFFFF)) begin
            freeze_cycles_d = freeze_cycles_q + 16'd1;
        end
        if (hz_if.mem_busy) begin
            if (wait_cnt_q == 8'd255) begin
                mem_timeout_d = 1'b1;
            end else begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end else begin
            wait_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= RUN;
            stall_cycles_q  <= 16'd0;
            freeze_cycles_q <= 16'd0;
            wait_cnt_q      <= 8'd0;
            mem_timeout_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            stall_cycles_q  <= stall_cycles_d;
            freeze_cycles_q <= freeze_cycles_d;
            wait_cnt_q      <= wait_cnt_d;
            mem_timeout_q   <= mem_timeout_d;
        end
    end

    assign hz_if.pc_write      = pc_write_d;
    assign hz_if.ifid_write    = ifid_write_d;
    assign hz_if.ifid_flush    = ifid_flush_d;
    assign hz_if.idex_bubble   = idex_bubble_d;
    assign hz_if.pipe_freeze   = pipe_freeze_d;
    assign hz_if.state         = state_q;
    assign hz_if.stall_cycles  = stall_cycles_q;
    assign hz_if.freeze_cycles = freeze_cycles_q;
    assign hz_if.mem_timeout   = mem_timeout_q;
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: per-cycle expected controls go through a scoreboard queue,
// registered state and counters are tracked by a small cycle model.
module tb_pipeline_hazard_ctrl;
    logic clk;
    logic rst;

    pipeline_hazard_ctrl_if bus ();

    pipeline_hazard_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .hz_if (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic pc;
        logic ifw;
        logic fl;
        logic bub;
        logic frz;
    } exp_t;

    exp_t sb_q[$];

    int vectors    = 0;
    int miscompares = 0;

    logic [1:0]  m_state   = 2'd0;
    logic [15:0] m_stall   = 16'd0;
    logic [15:0] m_freeze  = 16'd0;
    logic [7:0]  m_wait    = 8'd0;
    logic        m_timeout = 1'b0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                         input logic [4:0] exrd, input logic exw, input logic [4:0] memrd, input logic memw,
                         input logic br, input logic busy);
        bus.id_rs               = rs;
        bus.id_rt               = rt;
        bus.id_usesRs           = urs;
        bus.id_usesRt           = urt;
        bus.ex_rd               = exrd;
        bus.ex_ifWriteRegsFile  = exw;
        bus.mem_rd              = memrd;
        bus.mem_ifWriteRegsFile = memw;
        bus.id_branchTaken      = br;
        bus.mem_busy            = busy;
    endtask

    // One clock cycle: check the combinational controls, then the registered results after the edge.
    task automatic step(input string tag, input logic pc, input logic ifw, input logic fl,
                        input logic bub, input logic frz);
        exp_t e;
        exp_t got;
        e = '{pc: pc, ifw: ifw, fl: fl, bub: bub, frz: frz};
        sb_q.push_back(e);
        #2;
        got = sb_q.pop_front();
        check({tag, ".pc_write"},    {15'd0, bus.pc_write},    {15'd0, got.pc});
        check({tag, ".ifid_write"},  {15'd0, bus.ifid_write},  {15'd0, got.ifw});
        check({tag, ".ifid_flush"},  {15'd0, bus.ifid_flush},  {15'd0, got.fl});
        check({tag, ".idex_bubble"}, {15'd0, bus.idex_bubble}, {15'd0, got.bub});
        check({tag, ".pipe_freeze"}, {15'd0, bus.pipe_freeze}, {15'd0, got.frz});
        if (rst) begin
            m_state = 2'd0; m_stall = 16'd0; m_freeze = 16'd0; m_wait = 8'd0; m_timeout = 1'b0;
        end else begin
            m_state = bus.mem_busy ? 2'd2 : (got.bub ? 2'd1 : 2'd0);
            if (got.bub && m_stall != 16'hFFFF) m_stall++;
            if (got.frz && m_freeze != 16'hFFFF) m_freeze++;
            if (bus.mem_busy) begin
                if (m_wait == 8'd255) m_timeout = 1'b1;
                else m_wait++;
            end else begin
                m_wait = 8'd0;
            end
        end
        @(posedge clk);
        #1;
        check({tag, ".state"},         {14'd0, bus.state},  {14'd0, m_state});
        check({tag, ".stall_cycles"},  bus.stall_cycles,    m_stall);
        check({tag, ".freeze_cycles"}, bus.freeze_cycles,   m_freeze);
        check({tag, ".mem_timeout"},   {15'd0, bus.mem_timeout}, {15'd0, m_timeout});
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("rst0", 0, 0, 1, 1, 0);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1);
        step("rst1", 0, 0, 1, 1, 0);
        check("rst.state", {14'd0, bus.state}, 16'd0);
        check("rst.stall", bus.stall_cycles, 16'd0);
        rst = 1'b0;

        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("idle", 1, 1, 0, 0, 0);

        // rs hazard against EX, then the producer moves to MEM, then to WB
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("ex_haz1", 0, 0, 0, 1, 0);
        check("ex_haz1.state", {14'd0, bus.state}, 16'd1);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0);
        step("ex_haz2", 0, 0, 0, 1, 0);
        drive(5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("ex_haz3", 1, 1, 0, 0, 0);
        check("ex_haz.stall", bus.stall_cycles, 16'd2);

        drive(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("r0", 1, 1, 0, 0, 0);
        drive(5'd5, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        step("rs_unused", 1, 1, 0, 0, 0);
        drive(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0);
        step("mem_haz1", 0, 0, 0, 1, 0);
        drive(5'd0, 5'd7, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("mem_haz2", 1, 1, 0, 0, 0);
        check("mem_haz.stall", bus.stall_cycles, 16'd3);

        drive(5'd1, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 1'b1, 1'b0);
        step("br", 1, 1, 1, 0, 0);
        drive(5'd3, 5'd2, 1'b1, 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 1'b1, 1'b0);
        step("br_haz", 0, 0, 0, 1, 0);

        // memory wait during a hazard
        drive(5'd4, 5'd0, 1'b1, 1'b0, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step("busy_haz", 0, 0, 0, 0, 1);
        check("busy_haz.freeze", bus.freeze_cycles, 16'd3);
        check("busy_haz.state", {14'd0, bus.state}, 16'd2);
        bus.mem_busy = 1'b0;
        step("busy_haz_resume", 0, 0, 0, 1, 0);

        // watchdog: 256 consecutive busy cycles
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 255; i++) step("wd", 0, 0, 0, 0, 1);
        check("wd255.timeout", {15'd0, bus.mem_timeout}, 16'd0);
        step("wd256", 0, 0, 0, 0, 1);
        check("wd256.timeout", {15'd0, bus.mem_timeout}, 16'd1);
        bus.mem_busy = 1'b0;
        step("wd_drop", 1, 1, 0, 0, 0);
        check("wd_drop.timeout", {15'd0, bus.mem_timeout}, 16'd1);
        rst = 1'b1;
        step("wd_rst", 0, 0, 1, 1, 0);
        rst = 1'b0;
        check("wd_rst.timeout", {15'd0, bus.mem_timeout}, 16'd0);

        // saturate stall_cycles with a long hazard
        drive(5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 65540; i++) step("sat", 0, 0, 0, 1, 0);
        check("sat.stall", bus.stall_cycles, 16'hFFFF);

        // reset in the middle of a memory wait
        bus.mem_busy = 1'b1;
        step("mw1", 0, 0, 0, 0, 1);
        step("mw2", 0, 0, 0, 0, 1);
        rst = 1'b1;
        step("mw_rst", 0, 0, 1, 1, 0);
        rst = 1'b0;
        check("mw_rst.state", {14'd0, bus.state}, 16'd0);
        check("mw_rst.stall", bus.stall_cycles, 16'd0);
        check("mw_rst.freeze", bus.freeze_cycles, 16'd0);
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("post_rst", 1, 1, 0, 0, 0);

        // reset in the middle of a hazard
        drive(5'd6, 5'd0, 1'b1, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        step("hz_pre", 0, 0, 0, 1, 0);
        rst = 1'b1;
        step("hz_rst", 0, 0, 1, 1, 0);
        rst = 1'b0;
        drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        step("hz_post", 1, 1, 0, 0, 0);
        check("hz_post.stall", bus.stall_cycles, 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  clock; all state updates on rising edge.
REQ-002 SHALL have ports: rst  in  1  reset; synchronous, active-high.
REQ-003 SHALL have id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-004 SHALL have id_usesRs, id_usesRt  in  1 each  ID instruction reads rs / rt.
REQ-005 SHALL have ex_rd  in  5  and ex_ifWriteRegsFile  in  1  EX-stage destination and write enable.
REQ-006 SHALL have mem_rd  in  5  and mem_ifWriteRegsFile  in  1  MEM-stage destination and write enable.
REQ-007 SHALL have id_branchTaken  in  1  branch/jump resolved taken in ID.
REQ-008 SHALL have mem_busy  in  1  data memory not ready this cycle.
REQ-009 SHALL have pc_write  out  1  PC load enable.
REQ-010 SHALL have ifid_write  out  1  IF/ID load enable.
REQ-011 SHALL have ifid_flush  out  1  IF/ID clears to NOP next edge.
REQ-012 SHALL have idex_bubble  out  1  ID/EX loads all-zero control (bubble) next edge.
REQ-013 SHALL have pipe_freeze  out  1  ID/EX, EX/MEM and MEM/WB hold contents.
REQ-014 SHALL have state  out  2  FSM state: RUN=0, HAZ=1, MEMW=2.
REQ-015 SHALL have stall_cycles, freeze_cycles  out  16 each  saturating event counters.
REQ-016 SHALL have mem_timeout  out  1  sticky memory-wait watchdog flag.

Function
REQ-017 Hazard hz SHALL be 1 when, for rs (gated by id_usesRs) or rt (gated by id_usesRt), the register is nonzero and equals ex_rd with ex_ifWriteRegsFile=1 or mem_rd with mem_ifWriteRegsFile=1; WB-stage writers SHALL NOT cause a hazard (register file writes before it reads).
REQ-018 Outputs SHALL be combinational from inputs and state; priority mem_busy > hz > id_branchTaken.
REQ-019 mem_busy=1: pipe_freeze=1, pc_write=0, ifid_write=0, idex_bubble=0, ifid_flush=0; next state MEMW.
REQ-020 mem_busy=0, hz=1: pc_write=0, ifid_write=0, idex_bubble=1, ifid_flush=0, pipe_freeze=0; next state HAZ; id_branchTaken SHALL be ignored (operands stale).
REQ-021 mem_busy=0, hz=0, id_branchTaken=1: pc_write=1, ifid_write=1, ifid_flush=1, idex_bubble=0, pipe_freeze=0; next RUN.
REQ-022 Otherwise: pc_write=1, ifid_write=1, all other controls 0; next RUN.
REQ-023 A hazard against EX only SHALL produce exactly 2 bubble cycles; against MEM only, 1 bubble cycle (without intervening mem_busy).
REQ-024 stall_cycles SHALL increment each cycle idex_bubble=1; freeze_cycles each cycle pipe_freeze=1; both hold at 0xFFFF.
REQ-025 An 8-bit wait counter SHALL count consecutive mem_busy=1 cycles and clear when mem_busy=0; on the cycle mem_busy=1 with the counter at 255, mem_timeout SHALL set and stay 1 until rst; freezing continues regardless.
REQ-026 state output SHALL show the registered state (state of previous cycle's decision).

Reset
REQ-027 While rst=1: pc_write=0, ifid_write=0, ifid_flush=1, idex_bubble=1, pipe_freeze=0, regardless of other inputs.
REQ-028 After an rst edge: state=RUN, stall_cycles=0, freeze_cycles=0, wait counter=0, mem_timeout=0; rst asserted mid-MEMW or mid-HAZ SHALL abandon the sequence with no residual effect.

Verification
REQ-029 id_rs=5, id_usesRs=1, ex_rd=5, ex_ifWriteRegsFile=1, then the pipeline advancing rd into MEM -> idex_bubble=1 for 2 cycles, pc_write=0 for 2 cycles, stall_cycles=2.
REQ-030 id_rt=0, id_usesRt=1, ex_rd=0, ex_ifWriteRegsFile=1 -> no hazard, pc_write=1, idex_bubble=0.
REQ-031 id_branchTaken=1, no hazard -> ifid_flush=1, pc_write=1 one cycle; same with hz=1 -> ifid_flush=0, idex_bubble=1.
REQ-032 mem_busy=1 for 3 cycles during hz=1 -> pipe_freeze=1, idex_bubble=0 for 3 cycles, freeze_cycles=3, state=MEMW, then bubble resumes.
REQ-033 mem_busy=1 for 256 cycles -> mem_timeout=1 on cycle 256 and stays 1 after mem_busy drops; rst clears it.
REQ-034 stall_cycles preloaded to 0xFFFF via a long hazard -> stays 0xFFFF; rst mid-MEMW -> state=RUN, all counters 0.
